// File: rtl/fcmp_pipe.sv
// Two-stage binary32 compare (feq/flt/fle) with valid/ready on both sides.
// Stage 1 registers operand classification, stage 2 registers the result and drives the outputs.
module fcmp_pipe #(
  parameter int LAT         = 2,
  parameter bit RESERVED_NV = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        y,
  output logic        nv,
  output logic        nv_sticky,
  input  logic        nv_clr
);

  generate
    if (LAT != 2) begin : g_lat_chk
      $error("fcmp_pipe: only LAT=2 is supported");
    end
  endgenerate

  typedef struct packed {
    logic [1:0] op;
    logic       nan1;
    logic       nan2;
    logic       snan1;
    logic       snan2;
    logic       zero1;
    logic       zero2;
    logic       sign1;
    logic       sign2;
    logic       mag_lt;
    logic       mag_eq;
  } cls_t;

  cls_t s1_q, s1_d;
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic y_q, y_d, nv_q, nv_d;
  logic nv_sticky_q, nv_sticky_d;
  logic init_q;
  logic s1_adv, accept;
  logic in_nan1, in_nan2;
  logic any_nan, both_zero, eq, lt, res_y, res_nv;

  always_comb begin
    s1_adv     = !s2_valid_q || out_ready;
    // init_q keeps the unit closed while reset is asserted and until the first edge after release
    in_ready   = init_q && (!s1_valid_q || s1_adv);
    accept     = in_valid && in_ready;
    s1_valid_d = s1_adv ? accept : (s1_valid_q || accept);
    in_nan1    = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
    in_nan2    = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
    s1_d       = s1_q;
    if (accept) begin
      s1_d.op     = op;
      s1_d.nan1   = in_nan1;
      s1_d.nan2   = in_nan2;
      s1_d.snan1  = in_nan1 && !x1[22];
      s1_d.snan2  = in_nan2 && !x2[22];
      s1_d.zero1  = (x1[30:0] == 31'd0);
      s1_d.zero2  = (x2[30:0] == 31'd0);
      s1_d.sign1  = x1[31];
      s1_d.sign2  = x2[31];
      s1_d.mag_lt = (x1[30:0] < x2[30:0]);
      s1_d.mag_eq = (x1[30:0] == x2[30:0]);
    end
  end

  always_comb begin
    any_nan   = s1_q.nan1 || s1_q.nan2;
    both_zero = s1_q.zero1 && s1_q.zero2;
    // bitwise x1==x2 is equal magnitude plus equal sign
    eq = !any_nan && (both_zero || (s1_q.mag_eq && (s1_q.sign1 == s1_q.sign2)));
    lt = !any_nan && !both_zero &&
         ((s1_q.sign1 && !s1_q.sign2) ||
          (!s1_q.sign1 && !s1_q.sign2 && s1_q.mag_lt) ||
          (s1_q.sign1 && s1_q.sign2 && !s1_q.mag_lt && !s1_q.mag_eq));
    case (s1_q.op)
      2'b00: begin res_y = eq;       res_nv = s1_q.snan1 || s1_q.snan2; end
      2'b01: begin res_y = lt;       res_nv = any_nan;                  end
      2'b10: begin res_y = lt || eq; res_nv = any_nan;                  end
      default: begin res_y = 1'b0;   res_nv = RESERVED_NV;              end
    endcase
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
    y_d        = y_q;
    nv_d       = nv_q;
    if (s1_adv && s1_valid_q) begin
      y_d  = res_y;
      nv_d = res_nv;
    end
    nv_sticky_d = nv_sticky_q;
    if (nv_clr) nv_sticky_d = 1'b0;
    if (s2_valid_q && out_ready && nv_q) nv_sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      y_q         <= 1'b0;
      nv_q        <= 1'b0;
      nv_sticky_q <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      y_q         <= y_d;
      nv_q        <= nv_d;
      nv_sticky_q <= nv_sticky_d;
      init_q      <= 1'b1;
    end
  end

  assign out_valid = s2_valid_q;
  assign y         = y_q;
  assign nv        = nv_q;
  assign nv_sticky = nv_sticky_q;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed-table, corner-sequence and random bench for fcmp_pipe; results are
// checked in consume order against an expected-result queue.
`timescale 1ns/1ps
module tb_fcmp_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        y, nv, nv_sticky;
  logic        nv_clr = 1'b0;

  fcmp_pipe #(.LAT(2), .RESERVED_NV(1'b1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .x1(x1), .x2(x2), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .nv(nv), .nv_sticky(nv_sticky), .nv_clr(nv_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic y; logic nv; } exp_t;
  typedef struct { logic [1:0] op; logic [31:0] a; logic [31:0] b; logic ey; logic env; } vec_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   res_idx = 0;
  logic held = 1'b0;
  logic held_y, held_nv;
  logic rand_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Consume-order scoreboard plus stability check of a held result.
  always @(negedge clk) begin
    if (!rstn) begin
      held = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("y[%0d]", res_idx), {31'd0, y}, {31'd0, e.y});
          chk($sformatf("nv[%0d]", res_idx), {31'd0, nv}, {31'd0, e.nv});
          res_idx++;
        end
      end
      if (out_valid && !out_ready) begin
        if (held) begin
          chk("held_y", {31'd0, y}, {31'd0, held_y});
          chk("held_nv", {31'd0, nv}, {31'd0, held_nv});
        end
        held = 1'b1; held_y = y; held_nv = nv;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at 1 time unit after the accepting edge.
  task automatic send(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic ey, input logic env);
    int   n = 0;
    logic r;
    op = o; x1 = a; x2 = b; in_valid = 1'b1;
    do begin
      @(negedge clk); r = in_ready;
      @(posedge clk); n++;
    end while (!r && n < 200);
    if (!r) chk("accept_timeout", 32'd0, 32'd1);
    else exp_q.push_back('{ey, env});
    #1 in_valid = 1'b0;
  endtask

  // Returns 1 time unit after the edge that consumes the last expected result.
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  function automatic logic is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic real f2r(input logic [31:0] v);
    real m;
    int  e;
    e = int'(v[30:23]);
    m = real'(v[22:0]);
    if (e == 255)    m = 1.0e300;
    else if (e == 0) m = m * (2.0 ** (-149));
    else             m = (1.0 + m / 8388608.0) * (2.0 ** (e - 127));
    return v[31] ? -m : m;
  endfunction

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    real  ra, rb;
    logic nan_any, snan_any;
    ra = f2r(a); rb = f2r(b);
    nan_any  = is_nan(a) || is_nan(b);
    snan_any = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
    case (o)
      2'b00:   begin r.y = !nan_any && (ra == rb); r.nv = snan_any; end
      2'b01:   begin r.y = !nan_any && (ra < rb);  r.nv = nan_any;  end
      2'b10:   begin r.y = !nan_any && (ra <= rb); r.nv = nan_any;  end
      default: begin r.y = 1'b0;                   r.nv = 1'b1;     end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp(input int special_range);
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, special_range))
      0: v[30:23] = 8'hFF;
      1: v[30:0]  = '0;
      2: v[30:23] = 8'h00;
      default: ;
    endcase
    return v;
  endfunction

  vec_t vt[18];

  initial begin
    vt[0]  = '{2'b00, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0};
    vt[1]  = '{2'b00, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vt[2]  = '{2'b01, 32'hBF800000, 32'h3F800000, 1'b1, 1'b0};
    vt[3]  = '{2'b10, 32'h40000000, 32'h3F800000, 1'b0, 1'b0};
    vt[4]  = '{2'b01, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0};
    vt[5]  = '{2'b01, 32'h00000001, 32'h00000002, 1'b1, 1'b0};
    vt[6]  = '{2'b00, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b0};
    vt[7]  = '{2'b01, 32'h7FC00000, 32'h00000000, 1'b0, 1'b1};
    vt[8]  = '{2'b10, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0};
    vt[9]  = '{2'b01, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0};
    vt[10] = '{2'b01, 32'h80000000, 32'h00000000, 1'b0, 1'b0};
    vt[11] = '{2'b10, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    vt[12] = '{2'b01, 32'hFF800000, 32'h7F800000, 1'b1, 1'b0};
    vt[13] = '{2'b00, 32'h7F800000, 32'h7F800000, 1'b1, 1'b0};
    vt[14] = '{2'b10, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
    vt[15] = '{2'b00, 32'h00000001, 32'h00000000, 1'b0, 1'b0};
    vt[16] = '{2'b10, 32'hBF800000, 32'hBF800001, 1'b0, 1'b0};
    vt[17] = '{2'b11, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1};

    // reset state
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", {31'd0, y}, 32'd0);
    chk("rst_nv", {31'd0, nv}, 32'd0);
    chk("rst_nv_sticky", {31'd0, nv_sticky}, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // latency: accepted on the first edge, valid after the second
    send(vt[0].op, vt[0].a, vt[0].b, vt[0].ey, vt[0].env);
    chk("lat_edge1_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", {31'd0, out_valid}, 32'd1);
    drain();

    for (int i = 0; i < 18; i++) begin
      send(vt[i].op, vt[i].a, vt[i].b, vt[i].ey, vt[i].env);
      drain();
    end
    chk("sticky_after_table", {31'd0, nv_sticky}, 32'd1);

    // clear, then sNaN feq sets sticky on consume
    nv_clr = 1'b1;
    @(posedge clk); #1 nv_clr = 1'b0;
    chk("sticky_cleared", {31'd0, nv_sticky}, 32'd0);
    send(2'b00, 32'h7F800001, 32'h3F800000, 1'b0, 1'b1);
    drain();
    chk("sticky_snan", {31'd0, nv_sticky}, 32'd1);

    // clear and set in the same cycle: set wins; held result must not set early
    nv_clr = 1'b1;
    @(posedge clk); #1 nv_clr = 1'b0;
    out_ready = 1'b0;
    send(2'b01, 32'h7FC00000, 32'h00000000, 1'b0, 1'b1);
    @(posedge clk); #1;
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("sticky_while_held", {31'd0, nv_sticky}, 32'd0);
    out_ready = 1'b1; nv_clr = 1'b1;
    @(posedge clk); #1;
    chk("sticky_clr_and_set", {31'd0, nv_sticky}, 32'd1);
    @(posedge clk); #1;
    chk("sticky_clr_alone", {31'd0, nv_sticky}, 32'd0);
    nv_clr = 1'b0;
    drain();

    // backpressure: 5 back-to-back requests, out_ready low for 4 cycles
    out_ready = 1'b0;
    fork
      begin
        send(vt[7].op,  vt[7].a,  vt[7].b,  vt[7].ey,  vt[7].env);
        send(vt[0].op,  vt[0].a,  vt[0].b,  vt[0].ey,  vt[0].env);
        send(vt[3].op,  vt[3].a,  vt[3].b,  vt[3].ey,  vt[3].env);
        send(vt[17].op, vt[17].a, vt[17].b, vt[17].ey, vt[17].env);
        send(vt[2].op,  vt[2].a,  vt[2].b,  vt[2].ey,  vt[2].env);
      end
      begin
        @(posedge clk); #1;
        chk("bp_in_ready_s1_only", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("bp_in_ready_still_full", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();

    // random regression with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 500; i++) begin
          logic [31:0] a, b;
          logic [1:0]  o;
          exp_t        e;
          a = rnd_fp(7);
          b = ($urandom_range(0, 1) == 1) ? a : rnd_fp(5);
          o = 2'($urandom_range(0, 2));
          e = model(o, a, b);
          send(o, a, b, e.y, e.nv);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // async reset with both stages full discards everything in flight
    out_ready = 1'b0;
    send(2'b01, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b1);
    send(2'b10, 32'h40000000, 32'h3F800000, 1'b0, 1'b0);
    chk("pre_rst_full", {31'd0, out_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1 rstn = 1'b1;
    chk("rst_mid_sticky", {31'd0, nv_sticky}, 32'd0);
    @(posedge clk); #1 out_ready = 1'b1;
    send(2'b00, 32'h40490FDB, 32'h40490FDB, 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
